// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku move sequencer, input capture and display logic.
// The state encoding here is the game-state bus seen by the other blocks.
package sudoku_pkg;

    typedef enum logic [2:0] {
        EST_LINHA    = 3'b000,
        EST_COLUNA   = 3'b001,
        EST_VERIFICA = 3'b010,
        EST_VALOR    = 3'b011,
        EST_ESCREVE  = 3'b100,
        EST_ERRO     = 3'b101,
        EST_VITORIA  = 3'b110
    } estado_t;

    localparam logic [3:0] COD_NENHUM = 4'd0;
    localparam logic [3:0] COD_MAX    = 4'd9;

    // Codes 1..9 are usable row/column/value entries.
    function automatic logic cod_valido(input logic [3:0] cod);
        return (cod != COD_NENHUM) && (cod <= COD_MAX);
    endfunction

endpackage

// File: rtl/debouncer_botao.sv
// Enter-button conditioning: 2-flop synchronizer followed by a stable-low counter.
// Emits one single-cycle pulse per press; the button must be seen high before re-arming.
module debouncer_botao #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao_n,
    output logic pulso
);

    localparam int            CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_ALVO = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_UM   = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulso_q;
    logic          pulso_d;

    // Counter saturates at the target so a long hold yields only one pulse.
    always_comb begin
        cnt_d   = cnt_q;
        pulso_d = 1'b0;
        if (sync2_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_ALVO - CNT_UM) begin
            cnt_d   = CNT_ALVO;
            pulso_d = 1'b1;
        end else if (cnt_q != CNT_ALVO) begin
            cnt_d = cnt_q + CNT_UM;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchronizer idles high (button released) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= {CW{1'b0}};
            pulso_q <= 1'b0;
        end else begin
            sync1_q <= botao_n;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            pulso_q <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/controlador_jogada.sv
// Sudoku move sequencer: row -> column -> value -> checker handshake -> board write,
// with error hold-off, empty-cell tracking and victory detection.
module controlador_jogada
    import sudoku_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int ERRO_CYC     = 50000000,
    parameter int N_CELULAS    = 81
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       novo_jogo,
    input  logic [6:0] vazias_ini,
    input  logic       key_enter_n,
    input  logic [3:0] entrada_cod,
    input  logic       verif_ack,
    input  logic       verif_ok,
    output logic [2:0] estado_jogo,
    output logic [3:0] linha,
    output logic [3:0] coluna,
    output logic [3:0] valor,
    output logic       verif_req,
    output logic       escreve,
    output logic       erro,
    output logic       vitoria
);

    localparam int            VW        = $clog2(N_CELULAS + 1);
    localparam int            TW        = $clog2(ERRO_CYC + 1);
    localparam logic [VW-1:0] VAZ_UM    = VW'(1);
    localparam logic [TW-1:0] TIMER_UM  = TW'(1);
    localparam logic [TW-1:0] TIMER_INI = TW'(ERRO_CYC - 1);

    estado_t       estado_q, estado_d;
    logic [3:0]    linha_q, linha_d;
    logic [3:0]    coluna_q, coluna_d;
    logic [3:0]    valor_q, valor_d;
    logic [VW-1:0] vazias_q, vazias_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          verif_req_q, verif_req_d;
    logic          escreve_q, escreve_d;
    logic          erro_q, erro_d;
    logic          vitoria_q, vitoria_d;
    logic          pulso_s;

    debouncer_botao #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst_n),
        .botao_n(key_enter_n),
        .pulso  (pulso_s)
    );

    // Next-state and datapath; novo_jogo overrides everything, enable=0 freezes the rest.
    always_comb begin
        estado_d    = estado_q;
        linha_d     = linha_q;
        coluna_d    = coluna_q;
        valor_d     = valor_q;
        vazias_d    = vazias_q;
        timer_d     = timer_q;
        verif_req_d = verif_req_q;
        escreve_d   = 1'b0;
        if (novo_jogo) begin
            linha_d     = 4'd0;
            coluna_d    = 4'd0;
            valor_d     = 4'd0;
            verif_req_d = 1'b0;
            timer_d     = {TW{1'b0}};
            vazias_d    = VW'(vazias_ini);
            if (vazias_ini == 7'd0) begin
                estado_d = EST_VITORIA;
            end else begin
                estado_d = EST_LINHA;
            end
        end else if (!enable) begin
            estado_d = estado_q;
        end else begin
            case (estado_q)
                EST_LINHA, EST_COLUNA, EST_VALOR: begin
                    if (!pulso_s) begin
                        estado_d = estado_q;
                    end else if (entrada_cod == COD_NENHUM) begin
                        linha_d  = 4'd0;
                        coluna_d = 4'd0;
                        valor_d  = 4'd0;
                        estado_d = EST_LINHA;
                    end else if (cod_valido(entrada_cod)) begin
                        case (estado_q)
                            EST_LINHA: begin
                                linha_d  = entrada_cod;
                                estado_d = EST_COLUNA;
                            end
                            EST_COLUNA: begin
                                coluna_d = entrada_cod;
                                estado_d = EST_VALOR;
                            end
                            default: begin
                                valor_d     = entrada_cod;
                                verif_req_d = 1'b0;
                                estado_d    = EST_VERIFICA;
                            end
                        endcase
                    end else begin
                        linha_d  = 4'd0;
                        coluna_d = 4'd0;
                        valor_d  = 4'd0;
                        timer_d  = TIMER_INI;
                        estado_d = EST_ERRO;
                    end
                end
                EST_VERIFICA: begin
                    // Ack only counts once the request has actually been raised.
                    if (verif_req_q && verif_ack) begin
                        verif_req_d = 1'b0;
                        if (verif_ok) begin
                            escreve_d = 1'b1;
                            estado_d  = EST_ESCREVE;
                        end else begin
                            linha_d  = 4'd0;
                            coluna_d = 4'd0;
                            valor_d  = 4'd0;
                            timer_d  = TIMER_INI;
                            estado_d = EST_ERRO;
                        end
                    end else begin
                        verif_req_d = 1'b1;
                    end
                end
                EST_ESCREVE: begin
                    if (vazias_q > VAZ_UM) begin
                        vazias_d = vazias_q - VAZ_UM;
                        linha_d  = 4'd0;
                        coluna_d = 4'd0;
                        valor_d  = 4'd0;
                        estado_d = EST_LINHA;
                    end else begin
                        vazias_d = {VW{1'b0}};
                        estado_d = EST_VITORIA;
                    end
                end
                EST_ERRO: begin
                    if (timer_q == {TW{1'b0}}) begin
                        estado_d = EST_LINHA;
                    end else begin
                        timer_d = timer_q - TIMER_UM;
                    end
                end
                EST_VITORIA: begin
                    estado_d = EST_VITORIA;
                end
                default: begin
                    linha_d     = 4'd0;
                    coluna_d    = 4'd0;
                    valor_d     = 4'd0;
                    verif_req_d = 1'b0;
                    estado_d    = EST_LINHA;
                end
            endcase
        end
        erro_d    = (estado_d == EST_ERRO);
        vitoria_d = (estado_d == EST_VITORIA);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= EST_LINHA;
            linha_q     <= 4'd0;
            coluna_q    <= 4'd0;
            valor_q     <= 4'd0;
            vazias_q    <= {VW{1'b0}};
            timer_q     <= {TW{1'b0}};
            verif_req_q <= 1'b0;
            escreve_q   <= 1'b0;
            erro_q      <= 1'b0;
            vitoria_q   <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            linha_q     <= linha_d;
            coluna_q    <= coluna_d;
            valor_q     <= valor_d;
            vazias_q    <= vazias_d;
            timer_q     <= timer_d;
            verif_req_q <= verif_req_d;
            escreve_q   <= escreve_d;
            erro_q      <= erro_d;
            vitoria_q   <= vitoria_d;
        end
    end

    assign estado_jogo = estado_q;
    assign linha       = linha_q;
    assign coluna      = coluna_q;
    assign valor       = valor_q;
    assign verif_req   = verif_req_q;
    assign escreve     = escreve_q;
    assign erro        = erro_q;
    assign vitoria     = vitoria_q;

endmodule

// File: doc/controlador_jogada.md
Name: controlador_jogada

Overview:
Sequencer for one Sudoku move: row → column → value → validation → board write. Debounces the Enter button and latches the encoded switch value into the row/column/value registers. Runs a request/acknowledge exchange with the rule-checker, pulses the board write and tracks remaining empty cells to declare victory. Its estado_jogo output is the game-state bus consumed by the input-capture and display logic.

Parameters:
DEBOUNCE_CYC, 500000, cycles the synchronized button must be stable-low before a press is accepted (min 2).
ERRO_CYC, 50000000, cycles erro stays asserted before returning to row entry (min 1).
N_CELULAS, 81, maximum empty-cell count; sets the counter width (7 bits at default).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  high: FSM advances; low: FSM frozen, presses discarded
novo_jogo  in  1  synchronous start-new-game pulse
vazias_ini  in  7  empty cells in the new puzzle, sampled on novo_jogo
key_enter_n  in  1  raw Enter button, active-low, asynchronous
entrada_cod  in  4  encoded switch value: 0 = none/cancel, 1..9 valid, 10..15 invalid
verif_ack  in  1  checker acknowledge
verif_ok  in  1  checker verdict, sampled with verif_ack
estado_jogo  out  3  current state encoding
linha  out  4  latched row (1..9, 0 = unset)
coluna  out  4  latched column
valor  out  4  latched value
verif_req  out  1  validation request (level)
escreve  out  1  one-cycle board-write strobe
erro  out  1  error indicator
vitoria  out  1  puzzle solved

Behaviour:
- Reset: state LINHA (000); linha/coluna/valor = 0; vazias = 0; verif_req, escreve, erro, vitoria = 0; debouncer idle.
- Button path: 2-flop synchronizer, then a stable-low counter. A press generates exactly one internal 1-cycle pulse when the count reaches DEBOUNCE_CYC. The next press requires at least one synchronized-high sample. Pulse latency = 2 + DEBOUNCE_CYC cycles from the falling edge.
- States and encodings: LINHA 000, COLUNA 001, VERIFICA 010, VALOR 011, ESCREVE 100, ERRO 101, VITORIA 110. Code 111 is unreachable; it decodes to LINHA.
- On a press pulse in LINHA, COLUNA or VALOR, the action depends on entrada_cod:
  - 1..9: latch into the state's register and advance LINHA→COLUNA→VALOR→VERIFICA.
  - 0: cancel; clear all three registers and go to LINHA, no erro.
  - 10..15: go to ERRO.
- VERIFICA: verif_req = 1 from the cycle after entry and held until verif_ack is sampled high. On the ack cycle, verif_ok=1 → ESCREVE, else → ERRO. verif_req drops on the following cycle. Presses are ignored.
- ESCREVE: escreve = 1 for exactly one cycle; vazias decrements, saturating at 0. If the new value is 0 → VITORIA, else → LINHA with registers cleared.
- ERRO: erro = 1 on the entry cycle and for ERRO_CYC cycles total. Registers are cleared on entry. Then → LINHA. Presses are ignored.
- VITORIA: vitoria = 1; stays until novo_jogo.
- enable = 0: state, registers and timers hold. Press pulses are dropped, not queued. verif_req holds its value; an ack arriving while disabled is ignored, and the checker must hold ack until seen.
- novo_jogo has priority over every state, including mid-handshake and mid-ERRO:
  - next cycle: LINHA, registers cleared, verif_req/erro/vitoria = 0, vazias ← vazias_ini.
  - if vazias_ini = 0: → VITORIA instead.
  - novo_jogo acts even when enable = 0.
- A press pulse coinciding with novo_jogo is discarded.
- All outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Package sudoku_pkg holds the state encoding constants (shared with the input-capture and display blocks), COD_NENHUM = 0 and COD_MAX = 9.
- One sub-module, debouncer_botao (sync + stable counter + single-pulse), parameterized by DEBOUNCE_CYC.
- The FSM, registers, vazias counter and error timer stay in controlador_jogada.

Test Plan:
- Full move: with DEBOUNCE_CYC=4, vazias_ini=2, enter cod 3, 5, 7, ack with ok=1 → linha=3, coluna=5, valor=7; estado 000→001→011→010→100→000; one escreve pulse; vazias=1.
- Last cell: with vazias=1, complete a valid move → escreve pulse, then estado=110 and vitoria=1 held; further presses have no effect until novo_jogo.
- Rejection: in VERIFICA, return ack with ok=0 → estado=101, erro high exactly ERRO_CYC cycles (ERRO_CYC=3), registers = 0, then estado=000.
- Bad and cancel codes: cod 12 in LINHA → ERRO; cod 0 in VALOR after 4, 4 → estado=000, registers cleared, erro=0.
- Bounce and enable: a glitch low for 2 cycles produces no press; a held low of 10 cycles produces exactly one press; a press with enable=0 is dropped and the state is unchanged.
- Reset and new game: assert rst_n low asynchronously in VERIFICA → all outputs reset immediately. novo_jogo mid-ERRO → estado=000 next cycle, erro=0. novo_jogo with vazias_ini=0 → estado=110.
